// File: rtl/cla_key_operand_stager_if.sv
// Bus bundle between the key/operand stager and its neighbours: serial key load,
// operand handshake toward the locked adder, and the result handshake.
interface cla_key_operand_stager_if #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 16
);
    logic              key_start_i;
    logic              key_bit_i;
    logic              key_bit_valid_i;
    logic              key_busy_o;
    logic              key_ready_o;
    logic [KEY_W-1:0]  keyinput_o;
    logic              op_valid_i;
    logic              op_ready_o;
    logic [DATA_W-1:0] add1_i;
    logic [DATA_W-1:0] add2_i;
    logic [DATA_W-1:0] add1_o;
    logic [DATA_W-1:0] add2_o;
    logic [DATA_W:0]   sum_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [DATA_W:0]   result_o;

    // Upstream/bench side: drives key bits, operands, adder sum and result ready.
    modport master (
        output key_start_i, key_bit_i, key_bit_valid_i,
        output op_valid_i, add1_i, add2_i, sum_i, res_ready_i,
        input  key_busy_o, key_ready_o, keyinput_o,
        input  op_ready_o, add1_o, add2_o, res_valid_o, result_o
    );

    modport slave (
        input  key_start_i, key_bit_i, key_bit_valid_i,
        input  op_valid_i, add1_i, add2_i, sum_i, res_ready_i,
        output key_busy_o, key_ready_o, keyinput_o,
        output op_ready_o, add1_o, add2_o, res_valid_o, result_o
    );
endinterface

// File: rtl/cla_key_operand_stager.sv
// Serial key loader plus two-stage operand/result pipeline wrapped around an
// external key-locked carry lookahead adder.
module cla_key_operand_stager #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    cla_key_operand_stager_if.slave bus
);
    localparam int CNT_W = $clog2(KEY_W);

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t            state;
    logic              key_busy;
    logic              key_ready;
    logic [CNT_W-1:0]  cnt;
    logic [KEY_W-2:0]  shadow;
    logic [KEY_W-1:0]  key_q;

    logic [DATA_W-1:0] add1_p1;
    logic [DATA_W-1:0] add2_p1;
    logic              vld_p1;
    logic [DATA_W:0]   result_p2;
    logic              vld_p2;

    logic              s2_free;
    logic              op_ready;
    logic              accept;
    logic              capture;

    assign s2_free  = !vld_p2 || bus.res_ready_i;
    assign op_ready = (state == ARMED) && (!vld_p1 || s2_free) && !bus.key_start_i;
    assign accept   = bus.op_valid_i && op_ready;
    assign capture  = vld_p1 && s2_free;

    // Key loader: the last serial bit is merged straight into the committed key,
    // so the key bus only ever changes from one complete key to another.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= NOKEY;
            key_busy  <= 1'b0;
            key_ready <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
            key_q     <= '0;
        end else if (bus.key_start_i) begin
            state     <= LOAD;
            key_busy  <= 1'b1;
            key_ready <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
        end else if (state == LOAD && bus.key_bit_valid_i) begin
            if (cnt == CNT_W'(KEY_W - 1)) begin
                key_q     <= {bus.key_bit_i, shadow};
                cnt       <= '0;
                state     <= ARMED;
                key_busy  <= 1'b0;
                key_ready <= 1'b1;
            end else begin
                shadow[cnt] <= bus.key_bit_i;
                cnt         <= cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 holds operands in front of the adder; stage 2 captures its sum.
    // A key restart flushes both stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            add1_p1   <= '0;
            add2_p1   <= '0;
            vld_p1    <= 1'b0;
            result_p2 <= '0;
            vld_p2    <= 1'b0;
        end else if (bus.key_start_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept) begin
                add1_p1 <= bus.add1_i;
                add2_p1 <= bus.add2_i;
                vld_p1  <= 1'b1;
            end else if (capture) begin
                vld_p1 <= 1'b0;
            end

            if (capture) begin
                result_p2 <= bus.sum_i;
                vld_p2    <= 1'b1;
            end else if (bus.res_ready_i) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.key_busy_o  = key_busy;
    assign bus.key_ready_o = key_ready;
    assign bus.keyinput_o  = key_q;
    assign bus.op_ready_o  = op_ready;
    assign bus.add1_o      = add1_p1;
    assign bus.add2_o      = add2_p1;
    assign bus.res_valid_o = vld_p2;
    assign bus.result_o    = result_p2;
endmodule

// File: tb/tb_cla_key_operand_stager.sv
// Directed bench for cla_key_operand_stager with a behavioural locked adder in loop.
module tb_cla_key_operand_stager;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wrong_key_diff;

    cla_key_operand_stager_if #(.KEY_W(32), .DATA_W(16)) bus ();

    cla_key_operand_stager #(.KEY_W(32), .DATA_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Locked adder model: exact sum under key 0x2141831B, sum XOR a key-derived mask otherwise.
    function automatic logic [16:0] locked_add(input logic [15:0] a, input logic [15:0] b,
                                               input logic [31:0] k);
        logic [15:0] mask;
        mask = (k[15:0] ^ 16'h831B) ^ (k[31:16] ^ 16'h2141);
        return ({1'b0, a} + {1'b0, b}) ^ {1'b0, mask};
    endfunction

    assign bus.sum_i = locked_add(bus.add1_o, bus.add2_o, bus.keyinput_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial key load, LSB first, with an idle cycle before bits 3,10,17,24,31.
    task automatic send_key(input logic [31:0] k, input bit do_start);
        logic [31:0] old;
        int          bad;
        old = bus.keyinput_o;
        bad = 0;
        if (do_start) begin
            bus.key_start_i = 1'b1;
            tick();
            bus.key_start_i = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            if (i % 7 == 3) begin
                bus.key_bit_valid_i = 1'b0;
                tick();
            end
            bus.key_bit_valid_i = 1'b1;
            bus.key_bit_i       = k[i];
            tick();
            if (i < 31 && bus.keyinput_o !== old) bad++;
        end
        bus.key_bit_valid_i = 1'b0;
        chk("key_hold_until_commit", 64'(bad), 64'd0);
        chk("key_commit", 64'(bus.keyinput_o), 64'(k));
        chk("key_ready", 64'(bus.key_ready_o), 64'd1);
        chk("key_busy_after_commit", 64'(bus.key_busy_o), 64'd0);
    endtask

    // One pair through an idle pipeline; result expected after the second edge.
    task automatic issue_pair(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
        bus.op_valid_i = 1'b1;
        bus.add1_i     = a;
        bus.add2_i     = b;
        #1;
        chk("pair_op_ready", 64'(bus.op_ready_o), 64'd1);
        tick();
        bus.op_valid_i = 1'b0;
        chk("pair_add1_reg", 64'(bus.add1_o), 64'(a));
        chk("pair_add2_reg", 64'(bus.add2_o), 64'(b));
        chk("pair_not_yet_valid", 64'(bus.res_valid_o), 64'd0);
        tick();
        chk("pair_res_valid", 64'(bus.res_valid_o), 64'd1);
        chk("pair_result", 64'(bus.result_o), 64'(exp));
        if (bus.result_o !== ({1'b0, a} + {1'b0, b})) wrong_key_diff++;
        tick();
        chk("pair_drained", 64'(bus.res_valid_o), 64'd0);
    endtask

    initial begin
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic [16:0] got [$];
        int          acc;

        checks = 0;
        errors = 0;
        wrong_key_diff = 0;
        rst_n = 1'b0;
        bus.key_start_i = 1'b0;
        bus.key_bit_i = 1'b0;
        bus.key_bit_valid_i = 1'b0;
        bus.op_valid_i = 1'b0;
        bus.add1_i = '0;
        bus.add2_i = '0;
        bus.res_ready_i = 1'b1;

        repeat (2) tick();
        chk("rst_keyinput", 64'(bus.keyinput_o), 64'd0);
        chk("rst_busy", 64'(bus.key_busy_o), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a key load
        bus.key_start_i = 1'b1;
        tick();
        bus.key_start_i = 1'b0;
        chk("load_busy", 64'(bus.key_busy_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            bus.key_bit_valid_i = 1'b1;
            bus.key_bit_i = 1'(i);
            tick();
        end
        bus.key_bit_valid_i = 1'b0;
        rst_n = 1'b0;
        bus.op_valid_i = 1'b1;
        #1;
        chk("midrst_keyinput", 64'(bus.keyinput_o), 64'd0);
        chk("midrst_busy", 64'(bus.key_busy_o), 64'd0);
        chk("midrst_ready", 64'(bus.key_ready_o), 64'd0);
        chk("midrst_op_ready", 64'(bus.op_ready_o), 64'd0);
        chk("midrst_result", 64'(bus.result_o), 64'd0);
        chk("midrst_add1", 64'(bus.add1_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("nokey_op_ready", 64'(bus.op_ready_o), 64'd0);
        chk("nokey_busy", 64'(bus.key_busy_o), 64'd0);
        bus.op_valid_i = 1'b0;

        // Correct key, then single pairs
        send_key(32'h2141831B, 1'b1);
        issue_pair(16'h1234, 16'h4321, 17'h05555);
        issue_pair(16'hFFFF, 16'h0001, 17'h10000);

        // Back-to-back stream of 8 pairs
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'(i * 16'h2111 + 16'h0F0F);
            sb[i] = 16'(16'hE000 + i * 16'h0123);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.op_valid_i = 1'b1;
                bus.add1_i = sa[i];
                bus.add2_i = sb[i];
            end else begin
                bus.op_valid_i = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                chk("stream_valid", 64'(bus.res_valid_o), 64'd1);
                chk("stream_data", 64'(bus.result_o), 64'({1'b0, sa[i-1]} + {1'b0, sb[i-1]}));
            end
        end
        chk("stream_idle", 64'(bus.res_valid_o), 64'd0);

        // Backpressure: 4 stalled cycles, 3 pairs offered
        bus.res_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            bus.op_valid_i = 1'b1;
            bus.add1_i = (acc == 0) ? 16'h1234 : (acc == 1) ? 16'h0100 : 16'h7FFF;
            bus.add2_i = (acc == 0) ? 16'h4321 : (acc == 1) ? 16'h0200 : 16'h7FFF;
            #1;
            if (bus.op_ready_o) acc++;
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_op_ready", 64'(bus.op_ready_o), 64'd0);
        chk("bp_res_valid", 64'(bus.res_valid_o), 64'd1);
        chk("bp_result_held", 64'(bus.result_o), 64'h05555);
        bus.res_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.res_valid_o && bus.res_ready_i) got.push_back(bus.result_o);
            if (bus.op_valid_i && bus.op_ready_o) acc++;
            tick();
            if (acc == 3) bus.op_valid_i = 1'b0;
        end
        chk("drain_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("drain_0", 64'(got[0]), 64'h05555);
            chk("drain_1", 64'(got[1]), 64'h00300);
            chk("drain_2", 64'(got[2]), 64'h0FFFE);
        end

        // Key restart while results are in flight
        bus.res_ready_i = 1'b0;
        bus.op_valid_i = 1'b1;
        bus.add1_i = 16'h1111;
        bus.add2_i = 16'h2222;
        tick();
        bus.add1_i = 16'h3333;
        bus.add2_i = 16'h4444;
        tick();
        bus.op_valid_i = 1'b0;
        chk("pre_restart_valid", 64'(bus.res_valid_o), 64'd1);
        chk("pre_restart_result", 64'(bus.result_o), 64'h03333);
        bus.key_start_i = 1'b1;
        bus.key_bit_valid_i = 1'b1;
        bus.key_bit_i = 1'b1;
        #1;
        chk("restart_op_ready", 64'(bus.op_ready_o), 64'd0);
        tick();
        bus.key_start_i = 1'b0;
        bus.key_bit_valid_i = 1'b0;
        chk("restart_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("restart_busy", 64'(bus.key_busy_o), 64'd1);
        chk("restart_old_key", 64'(bus.keyinput_o), 64'h2141831B);
        bus.res_ready_i = 1'b1;
        tick();
        chk("restart_s1_flushed", 64'(bus.res_valid_o), 64'd0);
        send_key(32'h00000000, 1'b0);

        // Wrong key: pipeline timing unchanged, sums corrupted by the adder
        wrong_key_diff = 0;
        issue_pair(16'h1234, 16'h4321, 17'h0F70F);
        issue_pair(16'hFFFF, 16'h0001, 17'h1A25A);
        issue_pair(16'h0100, 16'h0200, 17'h0A15A);
        $display("wrong key: %0d of 3 results differ from the golden sum", wrong_key_diff);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_key_operand_stager.md
Name: cla_key_operand_stager

Overview:
- Upstream/downstream wrapper stage for the 16-bit key-locked carry lookahead adder.
- Loads the 32-bit key serially (LSB first) and presents it as a stable parallel `keyinput_o` bus.
- Registers operands into the combinational adder through a valid/ready handshake.
- Captures the adder's 17-bit sum into an output register with backpressure.
- Used in the partial-key simulation benches.
- The adder is instantiated alongside this block, not inside it.

Parameters:
- KEY_W, 32, key width; also the number of serial bits per load.
- DATA_W, 16, operand width; the result is DATA_W+1 bits.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- key_start_i  input  1  pulse: begin a new key load.
- key_bit_i  input  1  serial key bit.
- key_bit_valid_i  input  1  key_bit_i is valid this cycle.
- key_busy_o  output  1  high while in state LOAD.
- key_ready_o  output  1  high in state ARMED.
- keyinput_o  output  KEY_W  committed key, drives the adder's key bus.
- op_valid_i  input  1  operand pair valid.
- op_ready_o  output  1  stager accepts an operand pair.
- add1_i, add2_i  input  DATA_W  operands.
- add1_o, add2_o  output  DATA_W  registered operands to the adder.
- sum_i  input  DATA_W+1  adder result (combinational from add1_o/add2_o/keyinput_o).
- res_valid_o  output  1  result_o holds a valid result.
- res_ready_i  input  1  consumer accepts the result.
- result_o  output  DATA_W+1  captured sum.

Behaviour:
- Reset (async, rst_ni low):
  - State NOKEY.
  - keyinput_o=0, shadow=0, bit count=0.
  - add1_o=add2_o=0, s1_valid=0, res_valid_o=0, result_o=0.
  - key_busy_o=0, key_ready_o=0, op_ready_o=0.
  - Deassertion is synchronised by the testbench, not by this block.
- FSM states NOKEY, LOAD, ARMED:
  - key_start_i in any state → LOAD next cycle.
  - On that edge: count=0, shadow=0, s1_valid=0, res_valid_o=0 (in-flight work flushed).
  - keyinput_o keeps its old value until the next commit.
- LOAD:
  - Each cycle with key_bit_valid_i=1: shadow[count] ← key_bit_i, count++.
  - Cycles without valid are ignored.
  - On the valid bit with count=KEY_W-1: on that same edge, keyinput_o ← shadow with bit KEY_W-1 = key_bit_i, then count=0 and the FSM moves to ARMED.
  - The key bus changes only at commit and never shows a partial key.
- key_start_i and key_bit_valid_i in the same cycle: start wins and the bit is discarded.
- key_bit_valid_i in NOKEY or ARMED: ignored.
- Operand pipeline, two stages:
  - s2_free = !res_valid_o | res_ready_i.
  - op_ready_o = (state==ARMED) & (!s1_valid | s2_free) & !key_start_i.
  - Accept (op_valid_i & op_ready_o): add1_o/add2_o ← add1_i/add2_i, s1_valid←1.
  - If s1_valid & s2_free: result_o ← sum_i, res_valid_o←1, and s1_valid clears unless a new accept occurs the same edge.
  - res_valid_o & res_ready_i with no new capture: res_valid_o←0.
  - result_o holds while res_valid_o & !res_ready_i.
- Timing:
  - Latency: accept at edge N → res_valid_o high after edge N+1.
  - Throughput: 1 result/cycle with res_ready_i held high.
  - Full stall: at most one pair in s1 and one in result_o; op_ready_o low.
- add1_o/add2_o hold their last value when idle. No combinational path from add1_i/add2_i to any output.
- The stager performs no arithmetic on sum_i; width DATA_W+1 is passed through unchanged.

Test Plan:
- Reset mid-load after 10 key bits: all outputs 0, state NOKEY; op_ready_o stays 0 with op_valid_i=1.
- Serial load 0x2141831B (LSB first) with 5 idle gaps: keyinput_o stays 0 until the 32nd valid bit, then equals 0x2141831B on that edge; key_ready_o=1.
- Correct key, with the locked adder in loop:
  - 0x1234+0x4321 → result_o=0x05555 two cycles after accept.
  - 0xFFFF+0x0001 → 0x10000.
  - Back-to-back stream of 8 pairs, one result per cycle.
- Backpressure: res_ready_i=0 for 4 cycles with 3 pairs offered → 2 accepted, op_ready_o=0; result_o stays 0x05555; on release, results drain in order, none lost or duplicated.
- key_start_i with key_bit_valid_i and res_valid_o high in the same cycle: bit discarded, res_valid_o→0, s1 flushed; the old key is held on keyinput_o until the new 32-bit commit.
- Wrong key 0x00000000 loaded: the pipeline still produces one result per accept at 2-cycle latency; the bench logs the mismatch count versus the golden sum.
